// File: rtl/drbg_pkg.sv
// Shared definitions for the DRBG key buffer: default widths, slice count
// and the fill-side state encoding.
package drbg_pkg;

  localparam int WORD_W_DEF = 256;
  localparam int KEY_W_DEF  = 16;
  localparam int NSLICE     = WORD_W_DEF / KEY_W_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fill_state_e;

  // A new generator request may start only when the generator is usable,
  // idle, not asking for a reseed, and a buffer slot is free.
  function automatic logic fill_go(input logic init_ready,
                                   input logic next_ready,
                                   input logic do_reseed,
                                   input logic room);
    return init_ready && next_ready && !do_reseed && room;
  endfunction

endpackage

// File: rtl/drbg_key_buffer_if.sv
// Handshake between the Hash_DRBG generator and its key-buffer consumer.
// master = key buffer (issues requests), slave = generator.
interface drbg_key_buffer_if
  import drbg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              drbg_init_ready;
  logic              drbg_next_ready;
  logic              drbg_do_reseed;
  logic [WORD_W-1:0] drbg_random_bits;
  logic              drbg_next;

  modport master (
    output drbg_next,
    input  drbg_init_ready,
    input  drbg_next_ready,
    input  drbg_do_reseed,
    input  drbg_random_bits
  );

  modport slave (
    input  drbg_next,
    output drbg_init_ready,
    output drbg_next_ready,
    output drbg_do_reseed,
    output drbg_random_bits
  );

endinterface

// File: rtl/drbg_word_ram.sv
// DEPTH x WORD_W word store with one write port and one registered read
// port. The read register is write-first so a word written this cycle to
// the address being read is what appears on rd_data next cycle.
module drbg_word_ram
  import drbg_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int WORD_W = WORD_W_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write and write-first registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (we && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/drbg_key_buffer.sv
// Buffers 256-bit DRBG words and hands out one KEY_W slice per line strobe.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | no request in flight; start one when a slot is free
//   REQ       | drbg_next pulse is on the bus this cycle
//   WAIT_BUSY | waiting for the generator to drop next_ready
//   WAIT_DONE | generator busy; capture the word when next_ready rises
module drbg_key_buffer
  import drbg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  drbg_key_buffer_if.master          drbg,
  input  logic                       line_strobe,
  output logic [KEY_W-1:0]           key,
  output logic                       key_valid,
  output logic                       underflow,
  input  logic                       underflow_clr,
  output logic                       reseed_pending,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int SLICES = WORD_W / KEY_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int LW     = $clog2(DEPTH + 1);

  fill_state_e       state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [SW-1:0]     slice_idx;
  logic [WORD_W-1:0] rd_data;
  logic              take;
  logic              retire;
  logic              write;
  logic              room;

  // A strobe only consumes when a word is present; the last slice retires it.
  assign take       = line_strobe && (level != '0);
  assign retire     = take && (slice_idx == SW'(SLICES - 1));
  assign write      = (state == WAIT_DONE) && drbg.drbg_next_ready;
  assign room       = level < LW'(DEPTH);
  assign rd_ptr_nxt = retire ? rd_ptr + 1'b1 : rd_ptr;

  // The RAM is addressed with the next read pointer so rd_data always holds
  // the word at rd_ptr, including a word written in the previous cycle.
  drbg_word_ram #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk     (clk),
    .we      (write),
    .wr_addr (wr_ptr),
    .wr_data (drbg.drbg_random_bits),
    .rd_addr (rd_ptr_nxt),
    .rd_data (rd_data)
  );

  // Fill FSM with a registered single-cycle request pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      drbg.drbg_next <= 1'b0;
    end else begin
      drbg.drbg_next <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_go(drbg.drbg_init_ready, drbg.drbg_next_ready,
                      drbg.drbg_do_reseed, room)) begin
            state          <= REQ;
            drbg.drbg_next <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A reseed request before the generator starts cancels the word.
          if (drbg.drbg_do_reseed) begin
            state <= IDLE;
          end else if (!drbg.drbg_next_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (drbg.drbg_next_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pointers, slice index and occupancy; a write and a retire cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slice_idx <= '0;
      level     <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (take) begin
        slice_idx <= retire ? '0 : slice_idx + 1'b1;
      end
      if (write && !retire) begin
        level <= level + 1'b1;
      end else if (retire && !write) begin
        level <= level - 1'b1;
      end
    end
  end

  // Key output, valid pulse and sticky underflow (a new underflow beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      key       <= '0;
      key_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      key_valid <= take;
      if (take) begin
        key <= rd_data[int'(slice_idx) * KEY_W +: KEY_W];
      end
      if (line_strobe && (level == '0)) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Registered reseed/instantiation status for the controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      reseed_pending <= 1'b1;
    end else begin
      reseed_pending <= drbg.drbg_do_reseed || !drbg.drbg_init_ready;
    end
  end

endmodule

// File: tb/tb_drbg_key_buffer.sv
// Directed bench for drbg_key_buffer with a behavioural generator model.
module tb_drbg_key_buffer;
  import drbg_pkg::*;

  localparam int WORD_W = 256;
  localparam int KEY_W  = 16;
  localparam int DEPTH  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             line_strobe;
  logic             underflow_clr;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             underflow;
  logic             reseed_pending;
  logic [1:0]       level;

  drbg_key_buffer_if #(.WORD_W(WORD_W)) bus ();

  drbg_key_buffer #(
    .WORD_W (WORD_W),
    .KEY_W  (KEY_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .drbg           (bus),
    .line_strobe    (line_strobe),
    .key            (key),
    .key_valid      (key_valid),
    .underflow      (underflow),
    .underflow_clr  (underflow_clr),
    .reseed_pending (reseed_pending),
    .level          (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int pulses = 0;
  int gen_lat  = 20;
  int gen_drop = 0;
  bit gen_busy = 1'b0;

  logic [WORD_W-1:0] word_q [$];
  logic [WORD_W-1:0] w_one, w_two, w_slice, wb, wc, wu;

  // Count request pulses seen on the bus.
  always @(negedge clk) if (bus.drbg_next === 1'b1) pulses++;

  // Generator model: drops next_ready gen_drop cycles after a request,
  // stays busy gen_lat cycles, then presents the next queued word.
  initial begin
    bus.drbg_next_ready  = 1'b1;
    bus.drbg_random_bits = '0;
    forever begin
      @(negedge clk);
      if (bus.drbg_next === 1'b1) begin
        gen_busy = 1'b1;
        @(posedge clk);
        repeat (gen_drop) @(posedge clk);
        #1 bus.drbg_next_ready = 1'b0;
        repeat (gen_lat) @(posedge clk);
        #1;
        if (word_q.size() > 0) bus.drbg_random_bits = word_q.pop_front();
        else bus.drbg_random_bits = {8{32'hDEAD_BEEF}};
        bus.drbg_next_ready = 1'b1;
        gen_busy = 1'b0;
      end
    end
  end

  task automatic apply_reset(input logic init);
    @(negedge clk);
    reset = 1'b1;
    line_strobe = 1'b0;
    underflow_clr = 1'b0;
    bus.drbg_do_reseed = 1'b0;
    bus.drbg_init_ready = init;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b0;
  endtask

  task automatic quiesce();
    int n = 0;
    bus.drbg_init_ready = 1'b0;
    repeat (3) @(negedge clk);
    while (gen_busy && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (gen_busy) begin
      fails++;
      $display("FAIL quiesce: generator still busy after %0d cycles", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_level(input logic [1:0] want, input int budget, input string name);
    int n = 0;
    while (level !== want && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (level !== want) begin
      fails++;
      $display("FAIL %s: level=%0d, required %0d within %0d cycles", name, level, want, budget);
    end
  endtask

  task automatic wait_next(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.drbg_next !== 1'b1 && n < budget);
    checks++;
    if (bus.drbg_next !== 1'b1) begin
      fails++;
      $display("FAIL %s: drbg_next=%b, required 1 within %0d cycles", name, bus.drbg_next, budget);
    end
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (bus.drbg_next_ready !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (bus.drbg_next_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s: next_ready=%b, required 1 within %0d cycles", name, bus.drbg_next_ready, budget);
    end
  endtask

  task automatic test_reset_fill();
    int p0;
    word_q = {w_one, w_two};
    gen_lat = 20;
    gen_drop = 0;
    apply_reset(1'b1);
    checks += 6;
    if (bus.drbg_next !== 1'b0) begin fails++; $display("FAIL rst_next: got %b, required 0", bus.drbg_next); end
    if (key !== 16'h0000) begin fails++; $display("FAIL rst_key: got %h, required 0000", key); end
    if (key_valid !== 1'b0) begin fails++; $display("FAIL rst_key_valid: got %b, required 0", key_valid); end
    if (underflow !== 1'b0) begin fails++; $display("FAIL rst_underflow: got %b, required 0", underflow); end
    if (reseed_pending !== 1'b1) begin fails++; $display("FAIL rst_reseed_pending: got %b, required 1", reseed_pending); end
    if (level !== 2'd0) begin fails++; $display("FAIL rst_level: got %0d, required 0", level); end
    p0 = pulses;
    release_reset();
    wait_level(2'd2, 200, "fill_level");
    repeat (60) @(negedge clk);
    checks += 3;
    if (pulses - p0 != 2) begin fails++; $display("FAIL fill_pulses: got %0d, required 2", pulses - p0); end
    if (level !== 2'd2) begin fails++; $display("FAIL fill_level_hold: got %0d, required 2", level); end
    if (reseed_pending !== 1'b0) begin fails++; $display("FAIL fill_reseed_pending: got %b, required 0", reseed_pending); end
    // first key of word 0x..0001 is 0x0001
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    checks++;
    if (key !== 16'h0001 || key_valid !== 1'b1) begin
      fails++; $display("FAIL fill_first_key: got %h/%b, required 0001/1", key, key_valid);
    end
  endtask

  task automatic test_slice_order();
    logic [KEY_W-1:0] exp;
    quiesce();
    word_q = {w_slice, wb, wc};
    gen_lat = 20;
    apply_reset(1'b1);
    release_reset();
    wait_level(2'd2, 200, "slice_fill");
    line_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = 16'(i + 1);
      checks++;
      if (key !== exp || key_valid !== 1'b1) begin
        fails++; $display("FAIL slice_%0d: got %h/%b, required %h/1", i, key, key_valid, exp);
      end
    end
    line_strobe = 1'b0;
    checks++;
    if (level !== 2'd1) begin fails++; $display("FAIL slice_retire_level: got %0d, required 1", level); end
    wait_next(10, "slice_refill_req");
  endtask

  task automatic test_back_to_back();
    logic [KEY_W-1:0] exp;
    line_strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = 16'h2000 + 16'(i);
      checks++;
      if (key !== exp || key_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_%0d: got %h/%b, required %h/1", i, key, key_valid, exp);
      end
    end
    line_strobe = 1'b0;
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop: got %b, required 0", key_valid); end
  endtask

  task automatic test_underflow();
    quiesce();
    word_q = {wu};
    gen_lat = 100;
    apply_reset(1'b1);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      line_strobe = 1'b1;
      @(negedge clk);
      line_strobe = 1'b0;
      checks++;
      if (underflow !== 1'b1 || key_valid !== 1'b0 || key !== 16'h0000) begin
        fails++; $display("FAIL uf_empty_%0d: got uf=%b kv=%b key=%h, required 1/0/0000", i, underflow, key_valid, key);
      end
      @(negedge clk);
    end
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b, required 0", underflow); end
    underflow_clr = 1'b1;
    line_strobe = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    line_strobe = 1'b0;
    checks++;
    if (underflow !== 1'b1 || key_valid !== 1'b0) begin
      fails++; $display("FAIL uf_set_wins: got uf=%b kv=%b, required 1/0", underflow, key_valid);
    end
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL uf_clear2: got %b, required 0", underflow); end
    // strobe in the capture cycle still sees an empty buffer
    wait_ready(200, "uf_ready");
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    checks++;
    if (underflow !== 1'b1 || key_valid !== 1'b0 || level !== 2'd1) begin
      fails++; $display("FAIL uf_capture_cycle: got uf=%b kv=%b lvl=%0d, required 1/0/1", underflow, key_valid, level);
    end
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    checks++;
    if (key !== 16'h4000 || key_valid !== 1'b1 || underflow !== 1'b0) begin
      fails++; $display("FAIL uf_after_fill: got key=%h kv=%b uf=%b, required 4000/1/0", key, key_valid, underflow);
    end
  endtask

  task automatic test_reseed();
    int p0;
    int vc = 0;
    quiesce();
    word_q = {w_slice, wb};
    gen_lat = 10;
    gen_drop = 0;
    apply_reset(1'b1);
    release_reset();
    wait_level(2'd2, 200, "rs_fill");
    gen_drop = 5;
    p0 = pulses;
    line_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) vc++;
    end
    line_strobe = 1'b0;
    wait_next(10, "rs_req");
    bus.drbg_do_reseed = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 2'd1 || reseed_pending !== 1'b1) begin
      fails++; $display("FAIL rs_abort: got lvl=%0d rp=%b, required 1/1", level, reseed_pending);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (pulses - p0 != 1 || level !== 2'd1) begin
      fails++; $display("FAIL rs_no_req: got pulses=%0d lvl=%0d, required 1/1", pulses - p0, level);
    end
    line_strobe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) vc++;
    end
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    if (key_valid === 1'b1) vc++;
    checks += 2;
    if (vc != 32) begin fails++; $display("FAIL rs_key_count: got %0d, required 32", vc); end
    if (key !== 16'h200F || underflow !== 1'b1 || level !== 2'd0) begin
      fails++; $display("FAIL rs_drained: got key=%h uf=%b lvl=%0d, required 200f/1/0", key, underflow, level);
    end
    gen_drop = 0;
  endtask

  task automatic test_simul_write_retire();
    quiesce();
    word_q = {w_slice, wb, wc};
    gen_lat = 10;
    apply_reset(1'b1);
    release_reset();
    wait_level(2'd2, 200, "sim_fill");
    gen_lat = 40;
    line_strobe = 1'b1;
    repeat (31) @(negedge clk);
    line_strobe = 1'b0;
    wait_ready(100, "sim_ready");
    checks++;
    if (level !== 2'd1) begin fails++; $display("FAIL sim_pre_level: got %0d, required 1", level); end
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    checks++;
    if (level !== 2'd1 || key !== 16'h200F || key_valid !== 1'b1) begin
      fails++; $display("FAIL sim_level: got lvl=%0d key=%h kv=%b, required 1/200f/1", level, key, key_valid);
    end
    line_strobe = 1'b1;
    @(negedge clk);
    line_strobe = 1'b0;
    checks++;
    if (key !== 16'h3000 || key_valid !== 1'b1) begin
      fails++; $display("FAIL sim_next_word: got %h/%b, required 3000/1", key, key_valid);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    quiesce();
    word_q = {w_one};
    gen_lat = 30;
    apply_reset(1'b1);
    release_reset();
    wait_next(20, "mid_req");
    repeat (6) @(negedge clk);
    apply_reset(1'b0);
    release_reset();
    p0 = pulses;
    wait_ready(100, "mid_ready");
    repeat (3) @(negedge clk);
    checks++;
    if (level !== 2'd0 || pulses != p0 || reseed_pending !== 1'b1) begin
      fails++; $display("FAIL mid_ignored: got lvl=%0d pulses=%0d rp=%b, required 0/0/1", level, pulses - p0, reseed_pending);
    end
    bus.drbg_init_ready = 1'b1;
    wait_next(10, "mid_rereq");
    wait_level(2'd1, 100, "mid_refill");
  endtask

  initial begin
    reset = 1'b1;
    line_strobe = 1'b0;
    underflow_clr = 1'b0;
    bus.drbg_init_ready = 1'b0;
    bus.drbg_do_reseed = 1'b0;
    w_one = '0;
    w_one[0] = 1'b1;
    w_two = '0;
    w_two[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_slice[i*16 +: 16] = 16'(i + 1);
      wb[i*16 +: 16] = 16'h2000 + 16'(i);
      wc[i*16 +: 16] = 16'h3000 + 16'(i);
      wu[i*16 +: 16] = 16'h4000 + 16'(i);
    end
    test_reset_fill();
    test_slice_order();
    test_back_to_back();
    test_underflow();
    test_reseed();
    test_simul_write_retire();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
